router_in_fifo_p: RTL and testbench
===================================

// Module: router_in_fifo_p
// PURPOSE
//  Parametrised input-port buffer for the router: synchronous single-clock FIFO,
//  generic in data width and depth, with full/empty/almost-full/occupancy status,
//  sticky overflow/underflow error flags and synchronous flush. Sits between each
//  link input and the router's routing/arbitration logic; almost_full drives upstream backpressure.
// PARAMETERS
//  WIDTH        8   flit width in bits (>=1)
//  DEPTH        8   entries; power of two, >=2
//  AFULL_THRESH 6   almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
//  ADDR_W = $clog2(DEPTH), derived localparam; count is ADDR_W+1 bits
// PORTS
//  clk         in   1         clock; all state changes on rising edge
//  rst         in   1         asynchronous, active-low reset (0 = reset)
//  flush       in   1         sync clear of contents; priority over wr_en/rd_en
//  wr_en       in   1         write request
//  data_in     in   WIDTH     write data
//  rd_en       in   1         read request
//  data_out    out  WIDTH     registered read data
//  rd_valid    out  1         1 cycle after an accepted read; data_out valid
//  full        out  1         count == DEPTH
//  empty       out  1         count == 0
//  almost_full out  1         count >= AFULL_THRESH
//  count       out  ADDR_W+1  occupancy 0..DEPTH
//  overflow    out  1         sticky: a write was rejected
//  underflow   out  1         sticky: a read was rejected
//  clr_err     in   1         sync clear of overflow/underflow
// BEHAVIOUR
//  - Reset (rst=0, any time, async): rd/wr pointers=0, count=0, data_out=0, rd_valid=0,
//    overflow=0, underflow=0 -> empty=1, full=0, almost_full=0. Storage array not reset.
//  - rd_acc = rd_en & ~empty & ~flush.
//  - wr_acc = wr_en & ~flush & (~full | rd_acc): write when full allowed only with an
//    accepted read in the same cycle (write lands in the slot freed by the read).
//  - Read when empty with simultaneous write: read rejected, write accepted (no bypass).
//  - Accepted write: mem[wr_ptr]<=data_in; wr_ptr<=wr_ptr+1 mod DEPTH (natural wrap).
//  - Accepted read: data_out<=mem[rd_ptr]; rd_ptr<=rd_ptr+1 mod DEPTH; rd_valid<=1 next
//    cycle, else rd_valid<=0. data_out holds its last value when no read is accepted.
//  - count <= count + wr_acc - rd_acc; never exceeds DEPTH or underflows.
//  - full/empty/almost_full are combinational decodes of the count register (no lag).
//  - Read latency 1 cycle; data written in cycle N readable by rd_en in cycle N+1.
//  - Error flags: overflow<=1 when wr_en & ~flush & ~wr_acc; underflow<=1 when
//    rd_en & ~flush & ~rd_acc. Sticky until clr_err=1 or reset; on the same cycle a
//    new error event wins over clr_err (flag stays 1).
//  - flush=1: pointers=0, count=0, rd_valid<=0, data_out held; wr_en/rd_en ignored,
//    no error flagged.
//  - Ordering strictly FIFO across pointer wrap-around.
// TESTING (WIDTH=8, DEPTH=8, AFULL_THRESH=6)
//  1 Assert rst=0 mid-stream at count=3 -> same instant count=0, empty=1, data_out=0, rd_valid=0, flags=0.
//  2 Write 0x01..0x08 -> almost_full=1 after 6th, full=1 after 8th; 9th write 0xFF -> dropped,
//    overflow=1, count=8; read 8 -> data_out 0x01..0x08 in order, rd_valid each, then empty=1.
//  3 Write 5/read 5, then write 0xA0..0xA5/read 6 -> ptrs wrap, data out 0xA0..0xA5 in order.
//  4 Full with head 0x01: wr_en=rd_en=1, data_in=0x55 -> count stays 8, data_out=0x01,
//    0x55 read out last; no overflow.
//  5 Empty: wr_en=rd_en=1, data_in=0x33 -> underflow=1, rd_valid=0, count=1; next rd -> 0x33.
//  6 count=4, flush=1 with wr_en=1 -> count=0, empty=1, no overflow; clr_err=1 clears prior flags.

Source files
------------

// File: rtl/router_in_fifo_p.sv
// Router input-port buffer: single-clock FIFO with occupancy/status decode,
// sticky overflow/underflow flags and synchronous flush.
module router_in_fifo_p #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_err;
    logic              rd_err;

    assign full        = (count == CNT_FULL);
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_AFULL);

    // A write into a full FIFO is allowed only when a read frees the head slot
    // in the same cycle; a read on an empty FIFO never bypasses a concurrent write.
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_acc = wr_en & ~flush & (~full | rd_acc);
    assign wr_err = wr_en & ~flush & ~wr_acc;
    assign rd_err = rd_en & ~flush & ~rd_acc;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A fresh error event outranks clr_err so no rejection is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_err) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_err) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_in_fifo_p.sv
// Directed bench for router_in_fifo_p: a queue-based reference FIFO predicts
// every output each cycle, plus explicit checks at the interesting boundaries.
module tb_router_in_fifo_p;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf;
    logic             exp_unf;

    router_in_fifo_p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // Drive one cycle, advance the reference model, then compare every output.
    task automatic do_cycle(input logic w, input logic [WIDTH-1:0] d, input logic r,
                            input logic f, input logic c);
        int   sz;
        logic r_ok;
        logic w_ok;
        sz   = mq.size();
        r_ok = r && (sz > 0) && !f;
        w_ok = w && !f && ((sz < DEPTH) || r_ok);
        wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0; data_in = '0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        if (f) begin
            mq.delete();
        end else begin
            if (r_ok) exp_dout = mq.pop_front();
            if (w_ok) mq.push_back(d);
        end
        if (w && !f && !w_ok) exp_ovf = 1'b1;
        else if (c)           exp_ovf = 1'b0;
        if (r && !f && !r_ok) exp_unf = 1'b1;
        else if (c)           exp_unf = 1'b0;
        check("rd_valid",    32'(rd_valid),    32'(r_ok));
        check("data_out",    32'(data_out),    32'(exp_dout));
        check("count",       32'(count),       32'(mq.size()));
        check("empty",       32'(empty),       32'(mq.size() == 0));
        check("full",        32'(full),        32'(mq.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
        check("overflow",    32'(overflow),    32'(exp_ovf));
        check("underflow",   32'(underflow),   32'(exp_unf));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; data_in = '0; rd_en = 1'b0; clr_err = 1'b0;
        model_reset();
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_rdv",   32'(rd_valid), 32'd0);
        check("rst_dout",  32'(data_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Mid-stream async reset at count=3 with live read data
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'h11 * (i + 1), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_dout",  32'(data_out), 32'h11);
        #1;
        rst = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_dout",  32'(data_out), 32'd0);
        check("async_rdv",   32'(rd_valid), 32'd0);
        check("async_flags", 32'({overflow, underflow}), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill to full, overflow, drain in order
        for (int i = 1; i <= 8; i++) begin
            do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 5) check("afull_at5", 32'(almost_full), 32'd0);
            if (i == 6) check("afull_at6", 32'(almost_full), 32'd1);
            if (i == 7) check("full_at7",  32'(full), 32'd0);
        end
        check("full_at8", 32'(full), 32'd1);
        do_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("drain_data", 32'(data_out), 32'(i));
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);
        check("hold_dout",   32'(data_out), 32'h08);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Pointer wrap-around
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("wrap_data", 32'(data_out), 32'hA0 + 32'(i));
        end

        // Simultaneous read+write while full
        for (int i = 1; i <= 8; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("rw_full_count", 32'(count), 32'd8);
        check("rw_full_dout",  32'(data_out), 32'h01);
        check("rw_full_novf",  32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("rw_full_last", 32'(data_out), 32'h55);

        // Simultaneous read+write while empty: no bypass
        do_cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        check("rw_empty_unf",   32'(underflow), 32'd1);
        check("rw_empty_rdv",   32'(rd_valid), 32'd0);
        check("rw_empty_count", 32'(count), 32'd1);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("rw_empty_data", 32'(data_out), 32'h33);

        // Flush beats write; then error-flag clear and error-over-clear priority
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_novf",  32'(overflow), 32'd0);
        check("flush_dout",  32'(data_out), 32'h33);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("err_wins", 32'(underflow), 32'd1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 32'd0);
        do_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("post_flush_data", 32'(data_out), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
